// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment display scanner.
// Cycles through NUM_DIGITS anodes, PRESCALE cycles lit per digit, separated by
// GAP_CYCLES fully dark cycles so the previous digit's pattern never ghosts
// onto the next anode. New values are double-buffered and only swapped in at
// a frame boundary (or at once while dark) so a frame never mixes two values.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 50000,
  parameter int GAP_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      blank_lz,
  input  logic                      load_valid,
  input  logic [4*NUM_DIGITS-1:0]   load_data,
  output logic                      load_ready,
  output logic [6:0]                seg_n,
  output logic [NUM_DIGITS-1:0]     an_n,
  output logic                      frame_done
);

  localparam int VW = 4 * NUM_DIGITS;
  localparam int DW = $clog2(PRESCALE);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int IW = $clog2(NUM_DIGITS);

  localparam logic [DW-1:0] DWELL_LAST = DW'(PRESCALE - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_SCAN = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Standard hex font, segments {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  state_t                r_state, w_state_nxt;
  logic [IW-1:0]         r_idx, w_idx_nxt;
  logic [DW-1:0]         r_dwell, w_dwell_nxt;
  logic [GW-1:0]         r_gap, w_gap_nxt;

  logic [VW-1:0]         r_active, r_pending;
  logic                  r_pend_vld, r_load_ready;
  logic [6:0]            r_seg_n;
  logic [NUM_DIGITS-1:0] r_an_n;
  logic                  r_frame_done;

  logic                  w_accept, w_frame_end, w_xfer, w_pend_vld_nxt;
  logic [VW-1:0]         w_active_nxt;
  logic [3:0]            w_nib;
  logic [IW-1:0]         w_hi;
  logic                  w_blank;
  logic [6:0]            w_seg_nxt;
  logic [NUM_DIGITS-1:0] w_an_nxt;

  // Next state and counters; enable=0 overrides everything and zeroes the scan position.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_dwell_nxt = r_dwell;
    w_gap_nxt   = r_gap;
    if (!enable) begin
      w_state_nxt = S_OFF;
      w_idx_nxt   = '0;
      w_dwell_nxt = '0;
      w_gap_nxt   = '0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_nxt = S_SCAN;
          w_idx_nxt   = '0;
          w_dwell_nxt = '0;
          w_gap_nxt   = '0;
        end
        S_SCAN: begin
          if (r_dwell == DWELL_LAST) begin
            w_state_nxt = S_GAP;
            w_dwell_nxt = '0;
            w_gap_nxt   = '0;
          end else begin
            w_dwell_nxt = r_dwell + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) begin
            w_state_nxt = S_SCAN;
            w_gap_nxt   = '0;
            w_dwell_nxt = '0;
            w_idx_nxt   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
          end else begin
            w_gap_nxt = r_gap + 1'b1;
          end
        end
        default: w_state_nxt = S_OFF;
      endcase
    end
  end

  // Load handshake and frame-boundary transfer of pending into active.
  always_comb begin
    w_accept       = load_valid && r_load_ready;
    w_frame_end    = enable && (r_state == S_SCAN) && (r_dwell == DWELL_LAST) &&
                     (r_idx == IDX_LAST);
    w_xfer         = r_pend_vld && (w_frame_end || (r_state == S_OFF));
    w_active_nxt   = w_xfer ? r_pending : r_active;
    w_pend_vld_nxt = w_accept || (r_pend_vld && !w_xfer);
  end

  // Output decode from next-cycle values so the registered pins line up with the state.
  always_comb begin
    w_nib = 4'h0;
    w_hi  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_nxt == IW'(i)) w_nib = w_active_nxt[4*i +: 4];
      if (w_active_nxt[4*i +: 4] != 4'h0) w_hi = IW'(i);
    end
    // Digit 0 is never above w_hi, so it is never blanked.
    w_blank   = blank_lz && (w_idx_nxt > w_hi);
    w_seg_nxt = 7'h7F;
    w_an_nxt  = '1;
    if (w_state_nxt == S_SCAN) begin
      w_seg_nxt = w_blank ? 7'h7F : hex7(w_nib);
      for (int i = 0; i < NUM_DIGITS; i++)
        if (w_idx_nxt == IW'(i)) w_an_nxt[i] = 1'b0;
    end
  end

  // Scan state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_OFF;
      r_idx   <= '0;
      r_dwell <= '0;
      r_gap   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_dwell <= w_dwell_nxt;
      r_gap   <= w_gap_nxt;
    end
  end

  // Double-buffered display value; reset drops any pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active     <= '0;
      r_pending    <= '0;
      r_pend_vld   <= 1'b0;
      r_load_ready <= 1'b1;
    end else begin
      if (w_accept) r_pending <= load_data;
      r_active     <= w_active_nxt;
      r_pend_vld   <= w_pend_vld_nxt;
      r_load_ready <= !w_pend_vld_nxt;
    end
  end

  // Registered display pins and frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_n      <= 7'h7F;
      r_an_n       <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_seg_n      <= w_seg_nxt;
      r_an_n       <= w_an_nxt;
      r_frame_done <= w_frame_end;
    end
  end

  assign seg_n      = r_seg_n;
  assign an_n       = r_an_n;
  assign frame_done = r_frame_done;
  assign load_ready = r_load_ready;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with NUM_DIGITS=4, PRESCALE=4,
// GAP_CYCLES=1, so one frame is 4*(4+1) = 20 cycles.
module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        blank_lz;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int vec  = 0;
  int miss = 0;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS (4),
    .PRESCALE   (4),
    .GAP_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .blank_lz   (blank_lz),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the edge; load offers last one cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  // Checks a whole frame starting at digit 0, dwell 0. s0..s3 are the expected
  // segment patterns for digits 0..3. rdy_mid is load_ready after the first
  // cycle up to the frame-end gap (ready is 1 at the first and last sample).
  task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3, input logic rdy_mid);
    logic [6:0] segs [4];
    logic [3:0] ans  [4];
    segs = '{s0, s1, s2, s3};
    ans  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        chk({tag, "_an"},  32'(an_n),  32'(ans[d]));
        chk({tag, "_seg"}, 32'(seg_n), 32'(segs[d]));
        chk({tag, "_fd"},  32'(frame_done), 32'd0);
        chk({tag, "_rdy"}, 32'(load_ready), (d == 0 && c == 0) ? 32'd1 : 32'(rdy_mid));
        tick();
      end
      chk({tag, "_gap_an"},  32'(an_n),  32'hF);
      chk({tag, "_gap_seg"}, 32'(seg_n), 32'h7F);
      chk({tag, "_gap_fd"},  32'(frame_done), (d == 3) ? 32'd1 : 32'd0);
      chk({tag, "_gap_rdy"}, 32'(load_ready), (d == 3) ? 32'd1 : 32'(rdy_mid));
      tick();
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int expect_at;
    rst_n = 1'b0; enable = 1'b0; blank_lz = 1'b0; load_valid = 1'b0; load_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an",  32'(an_n),  32'hF);
    chk("rst_seg", 32'(seg_n), 32'h7F);
    chk("rst_fd",  32'(frame_done), 32'd0);
    chk("rst_rdy", 32'(load_ready), 32'd1);

    // Load while dark: accepted, then transferred on the next cycle.
    rst_n = 1'b1;
    load_valid = 1'b1; load_data = 16'h1234;
    tick();
    chk("off_load_busy", 32'(load_ready), 32'd0);
    tick();
    chk("off_load_done", 32'(load_ready), 32'd1);
    chk("off_dark_an",   32'(an_n), 32'hF);

    enable = 1'b1;
    tick();
    check_frame("f1_1234", 7'h19, 7'h30, 7'h24, 7'h79, 1'b1);

    // Mid-frame load: old value to the end of the frame, new one from next digit 0.
    load_valid = 1'b1; load_data = 16'h00A5;
    check_frame("f2_old", 7'h19, 7'h30, 7'h24, 7'h79, 1'b0);
    check_frame("f3_00A5", 7'h12, 7'h08, 7'h40, 7'h40, 1'b1);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    load_valid = 1'b1; load_data = 16'h0007;
    check_frame("f4_lz00A5", 7'h12, 7'h08, 7'h7F, 7'h7F, 1'b0);
    load_valid = 1'b1; load_data = 16'h0000;
    check_frame("f5_lz0007", 7'h78, 7'h7F, 7'h7F, 7'h7F, 1'b0);
    check_frame("f6_lz0000", 7'h40, 7'h7F, 7'h7F, 7'h7F, 1'b1);

    // Drop enable during digit 2, then re-enable.
    repeat (10) tick();
    chk("d2_an",  32'(an_n),  32'hB);
    chk("d2_seg", 32'(seg_n), 32'h7F);
    tick();
    enable = 1'b0;
    tick();
    chk("dis_an",  32'(an_n),  32'hF);
    chk("dis_seg", 32'(seg_n), 32'h7F);
    chk("dis_fd",  32'(frame_done), 32'd0);
    tick();
    chk("dis_hold_an", 32'(an_n), 32'hF);
    enable = 1'b1;
    tick();
    check_frame("f7_reen", 7'h40, 7'h7F, 7'h7F, 7'h7F, 1'b1);

    // Reset mid-dwell with a pending load.
    load_valid = 1'b1; load_data = 16'hFFFF;
    tick();
    chk("pre_rst_rdy", 32'(load_ready), 32'd0);
    chk("pre_rst_an",  32'(an_n), 32'hE);
    rst_n = 1'b0;
    #1;
    chk("arst_an",  32'(an_n),  32'hF);
    chk("arst_seg", 32'(seg_n), 32'h7F);
    chk("arst_rdy", 32'(load_ready), 32'd1);
    chk("arst_fd",  32'(frame_done), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    chk("post_rst_an",  32'(an_n),  32'hE);
    chk("post_rst_seg", 32'(seg_n), 32'h40);
    chk("post_rst_rdy", 32'(load_ready), 32'd1);

    // Frame period: pulses 19, 39, 59 cycles after digit 0 dwell 0.
    pulses = 0;
    for (int i = 1; i <= 70; i++) begin
      tick();
      if (frame_done) begin
        expect_at = 19 + 20 * pulses;
        chk("fd_period", 32'(i), 32'(expect_at));
        pulses++;
      end
    end
    chk("fd_count", 32'(pulses), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Parameters
REQ-001 SHALL provide NUM_DIGITS, default 4: number of multiplexed display digits (2..8).
REQ-002 SHALL provide PRESCALE, default 50000: clock cycles per digit dwell (≥4).
REQ-003 SHALL provide GAP_CYCLES, default 2: all-anodes-off cycles between digits, for anti-ghosting (≥1).

Interface
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port enable, input, 1: 1 = scan display, 0 = display dark.
REQ-007 SHALL have port blank_lz, input, 1: 1 = suppress leading zero digits.
REQ-008 SHALL have port load_valid, input, 1: new display value offered.
REQ-009 SHALL have port load_data, input, 4*NUM_DIGITS: hex nibbles; nibble 0 = rightmost digit.
REQ-010 SHALL have port load_ready, output, 1: controller can accept load_data.
REQ-011 SHALL have port seg_n, output, 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-012 SHALL have port an_n, output, NUM_DIGITS: digit anodes, active-low, one-hot-low when lit.
REQ-013 SHALL have port frame_done, output, 1: one-cycle pulse when digit NUM_DIGITS-1 dwell ends.

Function
REQ-014 SHALL register seg_n, an_n, frame_done and load_ready; no combinational input-to-output path.
REQ-015 SHALL implement FSM OFF, SCAN, GAP; OFF -> SCAN when enable=1; SCAN -> GAP when dwell counter = PRESCALE-1; GAP -> SCAN when gap counter = GAP_CYCLES-1; any state -> OFF when enable=0, with effect on the next edge.
REQ-016 SHALL, in SCAN, drive an_n low only on bit digit_idx and drive seg_n with the decode of the active display nibble.
REQ-017 SHALL, in OFF and GAP, drive an_n all ones and seg_n 7'h7F.
REQ-018 SHALL advance digit_idx on GAP -> SCAN, wrapping from NUM_DIGITS-1 to 0.
REQ-019 SHALL pulse frame_done for one cycle on SCAN -> GAP when digit_idx = NUM_DIGITS-1.
REQ-020 SHALL, on entry to OFF, clear digit_idx and the dwell and gap counters; the first SCAN after OFF shows digit 0.
REQ-021 SHALL decode nibbles per the standard hex font (0-9, A, b, C, d, E, F), e.g. 0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000, F -> 7'b0001110.
REQ-022 SHALL, when blank_lz=1, blank (seg_n = 7'h7F, anode still driven) each digit above the highest nonzero nibble; digit 0 SHALL never be blanked.
REQ-023 SHALL accept a load on a cycle with load_valid=1 and load_ready=1, capturing load_data into a pending register and driving load_ready to 0 on the next cycle.
REQ-024 SHALL copy pending into the active display register on the frame boundary (frame_done cycle) or immediately when the FSM is in OFF; load_ready SHALL return to 1 on the following cycle.
REQ-025 SHALL keep the active display register unchanged within a frame (no tearing).
REQ-026 SHALL preserve a pending value while enable toggles; an OFF-state transfer SHALL occur within one cycle.

Reset
REQ-027 SHALL, while rst_n=0, force state OFF, digit_idx 0, counters 0, active and pending registers 0, no pending load, an_n all ones, seg_n 7'h7F, frame_done 0, load_ready 1.
REQ-028 SHALL, on reset assertion mid-scan or mid-load, abandon the frame and discard any pending value.

Verification
REQ-029 Reset then enable=1, load 16'h1234 while OFF -> within 2 cycles active=1234; digits scan 4,3,2,1 patterns on an_n 1110,1101,1011,0111, each for PRESCALE cycles, separated by GAP_CYCLES dark cycles.
REQ-030 Load 16'h00A5 mid-frame -> load_ready=0 until frame_done; old value shown to frame end; new value from next digit 0.
REQ-031 blank_lz=1, value 16'h0007 -> digits 3..1 seg_n=7F, digit 0 seg_n=7'b1111000; value 16'h0000 -> digit 0 shows 7'b1000000.
REQ-032 Drop enable during digit 2 -> next cycle an_n=1111, seg_n=7F; re-enable -> scan restarts at digit 0 with full PRESCALE dwell.
REQ-033 Assert rst_n=0 mid-dwell with pending load -> outputs at reset values asynchronously; pending discarded; load_ready=1.
REQ-034 Run 3 frames with PRESCALE=4, GAP_CYCLES=1 -> frame_done pulses exactly every 4*(4+1)=20 cycles.
